// File: rtl/trap_ctrl_pkg.sv
// Shared definitions for the machine-mode trap controller: FSM states, trap-bus
// flag positions, cause codes, CSR bit positions and the redirect-target helper.
// Optional feature macro: VECTORED_MTVEC_EN (vectored interrupt targets).
package trap_ctrl_pkg;

  localparam int XLEN     = 64;
  localparam int INST_LEN = 32;
  localparam int TRAP_BUS = 3;
  localparam int CAUSE_W  = 4;

  // trap_bus_i flag positions
  localparam int TB_ECALL  = 0;
  localparam int TB_EBREAK = 1;
  localparam int TB_MRET   = 2;

  localparam logic [CAUSE_W-1:0] CAUSE_MSI    = 4'd3;
  localparam logic [CAUSE_W-1:0] CAUSE_MTI    = 4'd7;
  localparam logic [CAUSE_W-1:0] CAUSE_ECALL  = 4'd11;
  localparam logic [CAUSE_W-1:0] CAUSE_EBREAK = 4'd3;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;
  localparam int MIE_MSIE       = 3;
  localparam int MIE_MTIE       = 7;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SAVE     = 2'd1,
    ST_RESTORE  = 2'd2,
    ST_REDIRECT = 2'd3
  } state_e;

  // Vectored mode only applies to interrupts; exceptions always use the base.
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic irq,
                                                  input logic [CAUSE_W-1:0] cause);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
`ifdef VECTORED_MTVEC_EN
    if (irq && mtvec[1:0] == 2'b01)
      return base + (XLEN'(cause) << 2);
    else
      return base;
`else
    if (irq && cause == '0) return base;
    return base;
`endif
  endfunction

endpackage

// File: rtl/trap_arb.sv
// Combinational fixed-priority event selector: MSI > MTI > ecall > ebreak > mret.
module trap_arb
  import trap_ctrl_pkg::*;
(
  input  logic                inst_valid,
  input  logic                mstatus_mie,
  input  logic                mie_msie,
  input  logic                mie_mtie,
  input  logic                msip,
  input  logic                mtip,
  input  logic [TRAP_BUS-1:0] trap_bus,
  output logic                take_trap,
  output logic                take_mret,
  output logic                irq,
  output logic [CAUSE_W-1:0]  cause
);

  always_comb begin
    take_trap = 1'b0;
    take_mret = 1'b0;
    irq       = 1'b0;
    cause     = '0;
    if (inst_valid) begin
      if (mstatus_mie && mie_msie && msip) begin
        take_trap = 1'b1;
        irq       = 1'b1;
        cause     = CAUSE_MSI;
      end else if (mstatus_mie && mie_mtie && mtip) begin
        take_trap = 1'b1;
        irq       = 1'b1;
        cause     = CAUSE_MTI;
      end else if (trap_bus[TB_ECALL]) begin
        take_trap = 1'b1;
        cause     = CAUSE_ECALL;
      end else if (trap_bus[TB_EBREAK]) begin
        take_trap = 1'b1;
        cause     = CAUSE_EBREAK;
      end else if (trap_bus[TB_MRET]) begin
        take_mret = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: captures one trap/mret from the mem stage,
// updates the trap CSRs, then holds a fetch redirect until it is accepted.
// Optional feature macro: VECTORED_MTVEC_EN (see trap_ctrl_pkg::trap_target).
//
// Handshake: redirect_valid_o is held high with a stable redirect_pc_o until a
// cycle where redirect_ready_i is also high; that cycle is the transfer, flush_o
// pulses in it, and the controller returns to IDLE on the following edge.
module trap_ctrl
  import trap_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [INST_LEN-1:0] inst_data_i,
  input  logic                inst_valid_i,
  input  logic [TRAP_BUS-1:0] trap_bus_i,
  input  logic                mtip_i,
  input  logic                msip_i,
  input  logic [XLEN-1:0]     csr_mstatus_readdata_i,
  input  logic [XLEN-1:0]     csr_mie_readdata_i,
  input  logic [XLEN-1:0]     csr_mepc_readdata_i,
  input  logic [XLEN-1:0]     csr_mtvec_readdata_i,
  output logic [XLEN-1:0]     csr_mstatus_writedata_o,
  output logic [XLEN-1:0]     csr_mepc_writedata_o,
  output logic [XLEN-1:0]     csr_mcause_writedata_o,
  output logic [XLEN-1:0]     csr_mtval_writedata_o,
  output logic                csr_mstatus_write_valid_o,
  output logic                csr_mepc_write_valid_o,
  output logic                csr_mcause_write_valid_o,
  output logic                csr_mtval_write_valid_o,
  output logic [XLEN-1:0]     redirect_pc_o,
  output logic                redirect_valid_o,
  input  logic                redirect_ready_i,
  output logic                stall_o,
  output logic                flush_o,
  output logic                busy_o
);

  state_e state_q, state_d;

  logic [XLEN-1:0]     pc_q;
  logic [INST_LEN-1:0] inst_q;
  logic [CAUSE_W-1:0]  cause_q;
  logic                irq_q;
  logic [XLEN-1:0]     target_q;

  logic                take_trap, take_mret, sel_irq;
  logic [CAUSE_W-1:0]  sel_cause;
  logic [XLEN-1:0]     mstatus_save, mstatus_restore;

  trap_arb u_arb (
    .inst_valid  (inst_valid_i),
    .mstatus_mie (csr_mstatus_readdata_i[MSTATUS_MIE]),
    .mie_msie    (csr_mie_readdata_i[MIE_MSIE]),
    .mie_mtie    (csr_mie_readdata_i[MIE_MTIE]),
    .msip        (msip_i),
    .mtip        (mtip_i),
    .trap_bus    (trap_bus_i),
    .take_trap   (take_trap),
    .take_mret   (take_mret),
    .irq         (sel_irq),
    .cause       (sel_cause)
  );

  logic unused_ok;
  assign unused_ok = ^{csr_mie_readdata_i[XLEN-1:8], csr_mie_readdata_i[6:4],
                       csr_mie_readdata_i[2:0], csr_mtvec_readdata_i[1:0]};

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_trap)      state_d = ST_SAVE;
        else if (take_mret) state_d = ST_RESTORE;
      end
      ST_SAVE:     state_d = ST_REDIRECT;
      ST_RESTORE:  state_d = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready_i) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      inst_q   <= '0;
      cause_q  <= '0;
      irq_q    <= 1'b0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && (take_trap || take_mret)) begin
        pc_q    <= pc_i;
        inst_q  <= inst_data_i;
        cause_q <= sel_cause;
        irq_q   <= sel_irq;
      end
      if (state_q == ST_SAVE)    target_q <= trap_target(csr_mtvec_readdata_i, irq_q, cause_q);
      if (state_q == ST_RESTORE) target_q <= csr_mepc_readdata_i;
    end
  end

  always_comb begin
    mstatus_save                              = csr_mstatus_readdata_i;
    mstatus_save[MSTATUS_MPIE]                = csr_mstatus_readdata_i[MSTATUS_MIE];
    mstatus_save[MSTATUS_MIE]                 = 1'b0;
    mstatus_save[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mstatus_restore                              = csr_mstatus_readdata_i;
    mstatus_restore[MSTATUS_MIE]                 = csr_mstatus_readdata_i[MSTATUS_MPIE];
    mstatus_restore[MSTATUS_MPIE]                = 1'b1;
    mstatus_restore[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Write data is zero whenever its strobe is low so IDLE/reset drive all-zero.
  always_comb begin
    csr_mstatus_writedata_o   = '0;
    csr_mepc_writedata_o      = '0;
    csr_mcause_writedata_o    = '0;
    csr_mtval_writedata_o     = '0;
    csr_mstatus_write_valid_o = 1'b0;
    csr_mepc_write_valid_o    = 1'b0;
    csr_mcause_write_valid_o  = 1'b0;
    csr_mtval_write_valid_o   = 1'b0;
    redirect_pc_o             = '0;
    redirect_valid_o          = 1'b0;
    flush_o                   = 1'b0;
    stall_o                   = (state_q != ST_IDLE);
    busy_o                    = (state_q != ST_IDLE);
    case (state_q)
      ST_SAVE: begin
        csr_mstatus_write_valid_o = 1'b1;
        csr_mepc_write_valid_o    = 1'b1;
        csr_mcause_write_valid_o  = 1'b1;
        csr_mtval_write_valid_o   = 1'b1;
        csr_mstatus_writedata_o   = mstatus_save;
        csr_mepc_writedata_o      = pc_q;
        csr_mcause_writedata_o    = {irq_q, {(XLEN-1-CAUSE_W){1'b0}}, cause_q};
        if (!irq_q && cause_q == CAUSE_ECALL)
          csr_mtval_writedata_o = {{(XLEN-INST_LEN){1'b0}}, inst_q};
        else if (!irq_q && cause_q == CAUSE_EBREAK)
          csr_mtval_writedata_o = pc_q;
      end
      ST_RESTORE: begin
        csr_mstatus_write_valid_o = 1'b1;
        csr_mstatus_writedata_o   = mstatus_restore;
      end
      ST_REDIRECT: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = target_q;
        flush_o          = redirect_ready_i;
      end
      default: ;
    endcase
  end

endmodule
